// File: rtl/mux16_rr_arbiter_if.sv
// Request/grant bundle between the 16 requesters and the shared-mux arbiter.
// xfer_release is the owner's end-of-transfer strobe ("release" is a reserved word in SystemVerilog).
interface mux16_rr_arbiter_if;
    logic [15:0] req;
    logic        xfer_release;
    logic        grant_valid;
    logic [3:0]  grant_sel;
    logic [15:0] grant_onehot;
    logic        timeout;

    modport master (
        input  req,
        input  xfer_release,
        output grant_valid,
        output grant_sel,
        output grant_onehot,
        output timeout
    );

    modport slave (
        output req,
        output xfer_release,
        input  grant_valid,
        input  grant_sel,
        input  grant_onehot,
        input  timeout
    );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for a shared 16:1 mux; grants are held up to MAX_HOLD cycles. Optional ARB_PRIO0_EN makes requester 0 strict-priority.
// Latency: one cycle from req to grant_valid; back-to-back regrant at transfer end when another requester is waiting.
// Backpressure: none; the owner keeps the grant until release, request drop or hold-time expiry.
module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    mux16_rr_arbiter_if.master bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [3:0]         sel_q, sel_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               valid_q, valid_d;
    logic [15:0]        onehot_q, onehot_d;
    logic               timeout_q, timeout_d;
    logic               xfer_end;
    logic [15:0]        masked;
    logic [4:0]         pick;

    // Returns {hit, index} of the first set bit scanning start, start+1, ... mod 16.
    function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] start);
        logic [4:0] res;
        logic [3:0] idx;
        res = '0;
        for (int k = 15; k >= 0; k--) begin
            idx = start + 4'(k);
            if (r[idx]) res = {1'b1, idx};
        end
`ifdef ARB_PRIO0_EN
        if (r[0]) res = 5'b1_0000;
`endif
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        xfer_end  = 1'b0;
        masked    = '0;
        pick      = '0;
        case (state_q)
            IDLE: begin
                pick = rr_pick(bus.req, ptr_q);
                if (pick[4]) begin
                    state_d = GRANT;
                    sel_d   = pick[3:0];
                    hold_d  = '0;
                end
            end
            GRANT: begin
                xfer_end = bus.xfer_release | ~bus.req[sel_q] |
                           (hold_q == CNT_W'(MAX_HOLD - 1));
                if (!xfer_end) begin
                    hold_d = hold_q + CNT_W'(1);
                end else begin
                    ptr_d = sel_q + 4'd1;
`ifdef ARB_PRIO0_EN
                    // Requester 0 must not disturb the rotation of the others.
                    if (sel_q == 4'd0) ptr_d = ptr_q;
`endif
                    timeout_d = ~bus.xfer_release & bus.req[sel_q];
                    // The ending owner is masked so a timed-out requester cannot re-win immediately.
                    masked = bus.req & ~(16'd1 << sel_q);
                    pick   = rr_pick(masked, ptr_d);
                    hold_d = '0;
                    if (pick[4]) begin
                        sel_d = pick[3:0];
                    end else begin
                        state_d = IDLE;
                        sel_d   = 4'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 4'd0;
                hold_d  = '0;
            end
        endcase
        valid_d  = (state_d == GRANT);
        onehot_d = valid_d ? (16'd1 << sel_d) : 16'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 4'd0;
            sel_q     <= 4'd0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            onehot_q  <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            onehot_q  <= onehot_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant_valid  = valid_q;
    assign bus.grant_sel    = sel_q;
    assign bus.grant_onehot = onehot_q;
    assign bus.timeout      = timeout_q;

endmodule
